// File: rtl/acc_req_responder.sv
// Accelerator-side responder: queues committed requests in order, screens the
// opcode, issues legal ones to a backend unit and returns tagged responses.
module acc_req_responder #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TransIdBits = 3,
  parameter int unsigned Depth       = 4,
  parameter logic [6:0]  LegalOpcode = 7'b1010111
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            req_insn_i,
  input  logic [XLEN-1:0]        req_rs1_i,
  input  logic [XLEN-1:0]        req_rs2_i,
  input  logic [TransIdBits-1:0] req_trans_id_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [XLEN-1:0]        resp_result_o,
  output logic [TransIdBits-1:0] resp_trans_id_o,
  output logic                   resp_error_o,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [31:0]            be_insn_o,
  output logic [XLEN-1:0]        be_rs1_o,
  output logic [XLEN-1:0]        be_rs2_o,
  output logic                   be_valid_o,
  input  logic                   be_ready_i,
  input  logic                   be_done_i,
  input  logic [XLEN-1:0]        be_result_i,
  input  logic                   be_error_i,
  output logic                   busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [31:0]            insn;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [TransIdBits-1:0] tid;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state, state_d;
  req_t              fifo_mem [Depth];
  req_t              head;
  logic [PtrW-1:0]   wptr, rptr;
  logic [CntW-1:0]   count, count_d;
  logic              push, pop;
  logic              res_ld;
  logic [XLEN-1:0]   res_d;
  logic              err_d;

  assign push = req_valid_i && req_ready_o;
  assign head = fifo_mem[rptr];

  // FIFO storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wptr] <= '{insn: req_insn_i, rs1: req_rs1_i, rs2: req_rs2_i, tid: req_trans_id_i};
    end
  end

  // Next-state logic: pop/screen in IDLE, backend handshake, response handshake
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    res_ld  = 1'b0;
    res_d   = '0;
    err_d   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head.insn[6:0] != LegalOpcode) begin
            res_ld  = 1'b1;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (be_ready_i) begin
          if (be_done_i) begin
            res_ld  = 1'b1;
            res_d   = be_result_i;
            err_d   = be_error_i;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (be_done_i) begin
          res_ld  = 1'b1;
          res_d   = be_result_i;
          err_d   = be_error_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel out
  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + CntW'(1);
      2'b01:   count_d = count - CntW'(1);
      default: count_d = count;
    endcase
  end

  // State, pointers and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      count           <= '0;
      wptr            <= '0;
      rptr            <= '0;
      req_ready_o     <= 1'b1;
      busy_o          <= 1'b0;
      be_valid_o      <= 1'b0;
      resp_valid_o    <= 1'b0;
      be_insn_o       <= '0;
      be_rs1_o        <= '0;
      be_rs2_o        <= '0;
      resp_trans_id_o <= '0;
      resp_result_o   <= '0;
      resp_error_o    <= 1'b0;
    end else begin
      state        <= state_d;
      count        <= count_d;
      req_ready_o  <= (count_d != CntW'(Depth));
      busy_o       <= (count_d != '0) || (state_d != S_IDLE);
      be_valid_o   <= (state_d == S_ISSUE);
      resp_valid_o <= (state_d == S_RESP);
      if (push) begin
        wptr <= wptr + PtrW'(1);
      end
      if (pop) begin
        rptr            <= rptr + PtrW'(1);
        be_insn_o       <= head.insn;
        be_rs1_o        <= head.rs1;
        be_rs2_o        <= head.rs2;
        resp_trans_id_o <= head.tid;
      end
      if (res_ld) begin
        resp_result_o <= res_d;
        resp_error_o  <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_acc_req_responder.sv
// Directed bench for acc_req_responder: latency, illegal screening, backpressure,
// response hold, backend error, WAIT completion and mid-flight reset.
module tb_acc_req_responder;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TIDW = 3;
  localparam logic [31:0] LEGAL   = 32'h0000_0057;
  localparam logic [31:0] ILLEGAL = 32'h0000_0033;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [31:0]     req_insn_i;
  logic [XLEN-1:0] req_rs1_i, req_rs2_i;
  logic [TIDW-1:0] req_trans_id_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [XLEN-1:0] resp_result_o;
  logic [TIDW-1:0] resp_trans_id_o;
  logic            resp_error_o, resp_valid_o, resp_ready_i;
  logic [31:0]     be_insn_o;
  logic [XLEN-1:0] be_rs1_o, be_rs2_o;
  logic            be_valid_o, be_ready_i, be_done_i, be_error_i;
  logic [XLEN-1:0] be_result_i, be_result_v;
  logic            be_model;
  logic            busy_o;

  int compared = 0;
  int mismatched = 0;

  // Backend model: either a fixed value or rs1+rs2 of the issued operands
  assign be_result_i = be_model ? (be_rs1_o + be_rs2_o) : be_result_v;

  always #5 clk = ~clk;

  acc_req_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_insn_i(req_insn_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_trans_id_i(req_trans_id_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_result_o(resp_result_o), .resp_trans_id_o(resp_trans_id_o),
    .resp_error_o(resp_error_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .be_insn_o(be_insn_o), .be_rs1_o(be_rs1_o), .be_rs2_o(be_rs2_o),
    .be_valid_o(be_valid_o), .be_ready_i(be_ready_i), .be_done_i(be_done_i),
    .be_result_i(be_result_i), .be_error_i(be_error_i), .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] insn, input logic [63:0] rs1,
                           input logic [63:0] rs2, input logic [TIDW-1:0] tid);
    req_insn_i     = insn;
    req_rs1_i      = rs1;
    req_rs2_i      = rs2;
    req_trans_id_i = tid;
    req_valid_i    = 1'b1;
  endtask

  initial begin
    int accepted;
    int k;
    int waited;

    rst_i = 1'b1; req_valid_i = 1'b0; req_insn_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    req_trans_id_i = '0; resp_ready_i = 1'b1; be_ready_i = 1'b1; be_done_i = 1'b0;
    be_error_i = 1'b0; be_result_v = '0; be_model = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_be_valid", 64'(be_valid_o), 64'd0);
    chk("rst_result", resp_result_o, 64'd0);

    // Single legal request, backend done in handshake cycle
    drive_req(LEGAL, 64'd5, 64'd7, 3'd3);
    tick();                               // cycle 1
    req_valid_i = 1'b0;
    chk("legal_c1_be_valid", 64'(be_valid_o), 64'd0);
    chk("legal_c1_busy", 64'(busy_o), 64'd1);
    tick();                               // cycle 2
    chk("legal_c2_be_valid", 64'(be_valid_o), 64'd1);
    chk("legal_c2_rs1", be_rs1_o, 64'd5);
    chk("legal_c2_rs2", be_rs2_o, 64'd7);
    chk("legal_c2_insn", 64'(be_insn_o), 64'h57);
    be_done_i = 1'b1; be_result_v = 64'd12;
    tick();                               // cycle 3
    be_done_i = 1'b0;
    chk("legal_c3_resp_valid", 64'(resp_valid_o), 64'd1);
    chk("legal_c3_result", resp_result_o, 64'd12);
    chk("legal_c3_tid", 64'(resp_trans_id_o), 64'd3);
    chk("legal_c3_err", 64'(resp_error_o), 64'd0);
    chk("legal_c3_be_valid", 64'(be_valid_o), 64'd0);
    tick();                               // cycle 4
    chk("legal_c4_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("legal_c4_busy", 64'(busy_o), 64'd0);

    // Illegal opcode answered directly
    drive_req(ILLEGAL, 64'd9, 64'd9, 3'd1);
    tick();
    req_valid_i = 1'b0;
    chk("ill_c1_be_valid", 64'(be_valid_o), 64'd0);
    chk("ill_c1_resp_valid", 64'(resp_valid_o), 64'd0);
    tick();
    chk("ill_c2_resp_valid", 64'(resp_valid_o), 64'd1);
    chk("ill_c2_result", resp_result_o, 64'd0);
    chk("ill_c2_err", 64'(resp_error_o), 64'd1);
    chk("ill_c2_tid", 64'(resp_trans_id_o), 64'd1);
    chk("ill_c2_be_valid", 64'(be_valid_o), 64'd0);
    tick();
    chk("ill_c3_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("ill_c3_be_valid", 64'(be_valid_o), 64'd0);

    // Backpressure: backend stalled, push until full
    be_ready_i = 1'b0; be_model = 1'b1; be_done_i = 1'b1;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      drive_req(LEGAL, 64'(accepted + 100), 64'(accepted * 2), TIDW'(accepted));
      if (req_ready_o) accepted++;
      tick();
    end
    req_valid_i = 1'b0;
    chk("bp_accepted", 64'(accepted), 64'd5);
    chk("bp_ready_low", 64'(req_ready_o), 64'd0);
    chk("bp_be_valid", 64'(be_valid_o), 64'd1);
    be_ready_i = 1'b1;
    k = 0;
    for (int c = 0; c < 200 && k < 5; c++) begin
      if (resp_valid_o) begin
        chk("bp_tid", 64'(resp_trans_id_o), 64'(k));
        chk("bp_result", resp_result_o, 64'(3 * k + 100));
        chk("bp_err", 64'(resp_error_o), 64'd0);
        k++;
      end
      tick();
    end
    chk("bp_resp_count", 64'(k), 64'd5);
    chk("bp_idle_busy", 64'(busy_o), 64'd0);

    // Response held for 10 cycles, second request queued behind it
    resp_ready_i = 1'b0;
    drive_req(LEGAL, 64'h11, 64'h22, 3'd5);
    tick();
    drive_req(LEGAL, 64'h40, 64'h02, 3'd6);
    tick();
    req_valid_i = 1'b0;
    waited = 0;
    while (!resp_valid_o && waited < 50) begin
      tick();
      waited++;
    end
    chk("hold_reached", 64'(resp_valid_o), 64'd1);
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", 64'(resp_valid_o), 64'd1);
      chk("hold_result", resp_result_o, 64'h33);
      chk("hold_tid", 64'(resp_trans_id_o), 64'd5);
      chk("hold_be_valid", 64'(be_valid_o), 64'd0);
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    chk("hold_after_valid", 64'(resp_valid_o), 64'd0);
    chk("hold_after_busy", 64'(busy_o), 64'd1);
    tick();
    chk("next_be_valid", 64'(be_valid_o), 64'd1);
    chk("next_rs1", be_rs1_o, 64'h40);
    tick();
    chk("next_resp_valid", 64'(resp_valid_o), 64'd1);
    chk("next_tid", 64'(resp_trans_id_o), 64'd6);
    chk("next_result", resp_result_o, 64'h42);
    tick();

    // Backend error returned with a result
    be_model = 1'b0; be_error_i = 1'b1; be_result_v = 64'hDEAD;
    drive_req(LEGAL, 64'd1, 64'd1, 3'd2);
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    chk("berr_valid", 64'(resp_valid_o), 64'd1);
    chk("berr_err", 64'(resp_error_o), 64'd1);
    chk("berr_result", resp_result_o, 64'hDEAD);
    chk("berr_tid", 64'(resp_trans_id_o), 64'd2);
    tick();
    be_error_i = 1'b0; be_done_i = 1'b0;

    // Handshake without done goes through WAIT; done arrives later
    drive_req(LEGAL, 64'd3, 64'd4, 3'd4);
    tick();                               // cycle 1
    req_valid_i = 1'b0;
    tick();                               // cycle 2, ISSUE handshake
    tick();                               // cycle 3, WAIT
    chk("wait_be_valid", 64'(be_valid_o), 64'd0);
    chk("wait_resp_valid", 64'(resp_valid_o), 64'd0);
    be_done_i = 1'b1; be_result_v = 64'h77;
    tick();                               // cycle 4
    be_done_i = 1'b0;
    chk("wait_resp_valid2", 64'(resp_valid_o), 64'd1);
    chk("wait_result", resp_result_o, 64'h77);
    chk("wait_tid", 64'(resp_trans_id_o), 64'd4);
    tick();

    // Reset mid-WAIT with two entries queued
    drive_req(LEGAL, 64'd1, 64'd2, 3'd0);
    tick();
    drive_req(LEGAL, 64'd1, 64'd2, 3'd1);
    tick();
    drive_req(LEGAL, 64'd1, 64'd2, 3'd2);
    tick();                               // WAIT for tid0, tids 1,2 queued
    req_valid_i = 1'b0;
    chk("rw_be_valid", 64'(be_valid_o), 64'd0);
    chk("rw_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rw_ready", 64'(req_ready_o), 64'd1);
    chk("rw_busy0", 64'(busy_o), 64'd0);
    chk("rw_resp_valid", 64'(resp_valid_o), 64'd0);
    be_done_i = 1'b1; be_result_v = 64'h99;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rw_no_resp", 64'(resp_valid_o), 64'd0);
      chk("rw_no_busy", 64'(busy_o), 64'd0);
      chk("rw_no_issue", 64'(be_valid_o), 64'd0);
    end
    be_done_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
